disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clk cycles per digit step.
REQ-002 Parameter HOLD_FRAMES, default 256, meaning minimum scan frames a grant is held against competing requests.
REQ-003 Parameter BLINK_FRAMES, default 64, meaning frames per blink half-period.
REQ-004 Port clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port req  input  4  req[i] high: source i requests the display.
REQ-007 Ports data0..data3  input  16 each  four digit codes for source i; [3:0] is the rightmost digit, [15:12] the leftmost.
REQ-008 Port oth  input  16  oth[4*i+d] is the alternate-glyph flag for digit d of source i.
REQ-009 Port blink  input  4  blink[i] high: source i is displayed blinking.
REQ-010 Port an  output  4  active-low digit enable, registered.
REQ-011 Port num  output  4  digit code for the enabled digit, registered.
REQ-012 Port other  output  1  alternate-glyph flag for the enabled digit, registered.
REQ-013 Port grant  output  4  one-hot granted source, or 0000 when none is granted.
REQ-014 Port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be asserted in the cycle it equals SCAN_DIV-1.
REQ-016 Digit position pos SHALL step 0->1->2->3->0 on scan_tick; frame_tick SHALL be high on the scan_tick where pos wraps 3->0.
REQ-017 On each scan_tick, an SHALL load 1110/1101/1011/0111 for the new pos 0/1/2/3; num SHALL load data_g[4*pos+3:4*pos]; other SHALL load oth[4*g+pos], where g is the granted source.
REQ-018 With no grant, an SHALL be 1111, num SHALL be 0 and other SHALL be 0.
REQ-019 FSM states: IDLE (grant=0), HOLD (grant locked), OPEN (grant may be preempted); transitions SHALL occur only on frame_tick, so a frame never mixes sources.
REQ-020 IDLE: if req!=0 on frame_tick, grant the first requester searching round-robin from rr_ptr+1 mod 4, set rr_ptr to the winner, load hold count HOLD_FRAMES-1, and go to HOLD.
REQ-021 HOLD: on frame_tick, if hold count==0 go to OPEN; otherwise decrement.
REQ-022 OPEN: on frame_tick, if another source requests, grant it round-robin (current source searched last) and go to HOLD; else, if the current req is high, stay; else go to IDLE.
REQ-023 In HOLD or OPEN, if the granted source's req is low at frame_tick: re-arbitrate among the others as in REQ-020, or go to IDLE if none requests.
REQ-024 On a frame_tick that changes grant, the outputs loaded that cycle (pos 0) SHALL already use the new grant.
REQ-025 Latency: from req asserted with the FSM in IDLE to grant SHALL be at most 4*SCAN_DIV cycles.
REQ-026 Changes on data/oth SHALL take effect at the next scan_tick; no input is latched otherwise.

Reset
REQ-027 rst high SHALL immediately force an=1111, num=0, other=0, grant=0000, frame_tick=0, pos=0, prescaler=0, state=IDLE, rr_ptr=3 (source 0 wins first), hold count=0, blink phase=visible.
REQ-028 rst asserted mid-frame or mid-HOLD SHALL abandon the grant; after release, arbitration SHALL restart from the first frame_tick.

Configuration
REQ-029 Macro DISP_ARBITER_BLINK_EN defined: a frame counter toggles blink phase every BLINK_FRAMES frames; while phase=hidden and blink[g]=1, an SHALL load 1111 (num and other update normally).
REQ-030 Macro undefined: blink SHALL be ignored and no blink counter SHALL exist; an always follows REQ-017.

Verification (SCAN_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2)
REQ-031 rst pulse, req=0000 for 3 frames -> an=1111, grant=0000 throughout; frame_tick every 16 cycles.
REQ-032 req=0001, data0=16'h1234 -> grant=0001 at the first frame_tick; an 1110/1101/1011/0111 with num 4/3/2/1, each held 4 cycles.
REQ-033 req=0011 from IDLE -> grant 0001 for 3 frames (HOLD 2 + first OPEN frame), then 0010 for 3 frames, then 0001 again.
REQ-034 req drops from 0001 to 0000 during HOLD -> grant=0000, an=1111 from the next frame_tick.
REQ-035 DISP_ARBITER_BLINK_EN, req=0001, blink=0001 -> digits visible for 2 frames, an=1111 for 2 frames, repeating; macro undefined -> always visible.
REQ-036 rst asserted at cycle 6 of a frame with grant=0010 -> an=1111, grant=0000 before the next clk edge; after release, grant=0010 (req=0010) at the first frame_tick.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: multiplexes four 4-digit sources onto one scanned display.
// A frame is four digit steps; grant changes only on frame boundaries.
// Round-robin arbitration, with a minimum hold period before preemption.
// Optional blink support is enabled with `define DISP_ARBITER_BLINK_EN.
module disp_arbiter #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned HOLD_FRAMES  = 256,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic [15:0] oth,
  input  logic [3:0]  blink,
  output logic [3:0]  an,
  output logic [3:0]  num,
  output logic        other,
  output logic [3:0]  grant,
  output logic        frame_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_t;

  logic [CW-1:0] cnt;
  logic          scan_tick;
  logic [1:0]    pos;
  logic [1:0]    pos_nxt;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    grant_nxt;
  logic [1:0]    gidx;
  logic [1:0]    gidx_nxt;
  logic [1:0]    rr_ptr;
  logic [1:0]    rr_nxt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;

  logic [2:0]    pick_all;
  logic [2:0]    pick_oth;
  logic [15:0]   dsel;
  logic          hidden;

  // First set bit of mask searching upward from start (mod 4); {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!res[2] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Prescaler: one scan_tick every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (scan_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign scan_tick  = (cnt == CNT_MAX);
  assign pos_nxt    = pos + 2'd1;
  assign frame_tick = scan_tick && (pos == 2'd3);

  // Digit position steps once per scan_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= 2'd0;
    end else if (scan_tick) begin
      pos <= pos_nxt;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 4'b0000;
      gidx   <= 2'd0;
      rr_ptr <= 2'd3;
      hold   <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_nxt;
      hold   <= hold_nxt;
    end
  end

  // Next-state: decisions only on frame_tick so a frame never mixes sources.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold;
    pick_all  = rr_pick(req, rr_ptr + 2'd1);
    pick_oth  = rr_pick(req & ~grant, gidx + 2'd1);
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (pick_all[2]) begin
            state_nxt = HOLD;
            grant_nxt = 4'b0001 << pick_all[1:0];
            gidx_nxt  = pick_all[1:0];
            rr_nxt    = pick_all[1:0];
            hold_nxt  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (!req[gidx]) begin
            if (pick_oth[2]) begin
              grant_nxt = 4'b0001 << pick_oth[1:0];
              gidx_nxt  = pick_oth[1:0];
              rr_nxt    = pick_oth[1:0];
              hold_nxt  = HOLD_LOAD;
            end else begin
              state_nxt = IDLE;
              grant_nxt = 4'b0000;
              hold_nxt  = '0;
            end
          end else if (hold == '0) begin
            state_nxt = OPEN;
          end else begin
            hold_nxt = hold - HW'(1);
          end
        end
        OPEN: begin
          if (pick_oth[2]) begin
            state_nxt = HOLD;
            grant_nxt = 4'b0001 << pick_oth[1:0];
            gidx_nxt  = pick_oth[1:0];
            rr_nxt    = pick_oth[1:0];
            hold_nxt  = HOLD_LOAD;
          end else if (!req[gidx]) begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            hold_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Digit codes of the source that owns the display after this edge.
  always_comb begin
    dsel = 16'h0000;
    case (gidx_nxt)
      2'd0:    dsel = data0;
      2'd1:    dsel = data1;
      2'd2:    dsel = data2;
      default: dsel = data3;
    endcase
  end

`ifdef DISP_ARBITER_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          phase_nxt;

  assign phase_nxt = (frame_tick && (blink_cnt == BLINK_LAST)) ? ~phase : phase;
  assign hidden    = phase_nxt && blink[gidx_nxt];

  // Frame counter toggling the blink phase (0 = visible).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      phase <= phase_nxt;
    end
  end
`else
  localparam int unsigned unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^blink;
  assign hidden       = 1'b0;
`endif

  // Display outputs, loaded for the new position on each scan_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an    <= 4'b1111;
      num   <= 4'h0;
      other <= 1'b0;
    end else if (scan_tick) begin
      if (grant_nxt == 4'b0000) begin
        an    <= 4'b1111;
        num   <= 4'h0;
        other <= 1'b0;
      end else begin
        an    <= hidden ? 4'b1111 : ~(4'b0001 << pos_nxt);
        num   <= dsel[{pos_nxt, 2'b00} +: 4];
        other <= oth[{gidx_nxt, pos_nxt}];
      end
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed test of disp_arbiter with SCAN_DIV=4,
// HOLD_FRAMES=2, BLINK_FRAMES=2 (16-cycle frames).
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic [15:0] oth;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [3:0]  num;
  logic        other;
  logic [3:0]  grant;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  disp_arbiter #(
    .SCAN_DIV    (4),
    .HOLD_FRAMES (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .oth       (oth),
    .blink     (blink),
    .an        (an),
    .num       (num),
    .other     (other),
    .grant     (grant),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check one whole frame starting at its cycle 0; returns at cycle 0 of the next.
  task automatic expect_frame(input string tag, input logic [3:0] g, input logic [15:0] d,
                              input logic [3:0] o, input logic vis);
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int c = 0; c < 16; c++) begin
      int p;
      logic [3:0] ea, en;
      logic eo;
      p  = c / 4;
      ea = (g == 4'b0000 || !vis) ? 4'b1111 : an_tab[p];
      en = (g == 4'b0000) ? 4'h0 : d[4*p +: 4];
      eo = (g == 4'b0000) ? 1'b0 : o[p];
      check({tag, ".grant"}, 16'(grant), 16'(g));
      check({tag, ".an"}, 16'(an), 16'(ea));
      check({tag, ".num"}, 16'(num), 16'(en));
      check({tag, ".other"}, 16'(other), 16'(eo));
      check({tag, ".frame_tick"}, 16'(frame_tick), 16'(c == 15));
      @(negedge clk);
    end
  endtask

  // Reset pulse; returns at the negedge where the first frame begins.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Check the reset values of all outputs.
  task automatic check_reset(input string tag);
    check({tag, ".an"}, 16'(an), 16'hF);
    check({tag, ".num"}, 16'(num), 16'h0);
    check({tag, ".other"}, 16'(other), 16'h0);
    check({tag, ".grant"}, 16'(grant), 16'h0);
    check({tag, ".frame_tick"}, 16'(frame_tick), 16'h0);
  endtask

  logic vis_a, vis_b;

  initial begin
    rst   = 1'b0;
    req   = 4'b0000;
    data0 = 16'h1234;
    data1 = 16'h5678;
    data2 = 16'h9ABC;
    data3 = 16'hDEF0;
    oth   = 16'h00A5;
    blink = 4'b0000;
    #1 rst = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle display for three frames.
    expect_frame("idle0", 4'b0000, data0, 4'h5, 1'b1);
    expect_frame("idle1", 4'b0000, data0, 4'h5, 1'b1);
    expect_frame("idle2", 4'b0000, data0, 4'h5, 1'b1);

    // Single requester granted at the next frame boundary.
    req = 4'b0001;
    expect_frame("single_wait", 4'b0000, 16'h1234, 4'h5, 1'b1);
    expect_frame("single_g", 4'b0001, 16'h1234, 4'h5, 1'b1);

    // Request drops during HOLD: released at the following boundary.
    req = 4'b0000;
    expect_frame("drop_last", 4'b0001, 16'h1234, 4'h5, 1'b1);
    expect_frame("drop_idle", 4'b0000, 16'h1234, 4'h5, 1'b1);

    // Two requesters alternate: 3 frames each.
    do_reset();
    req = 4'b0011;
    expect_frame("rr_wait", 4'b0000, 16'h1234, 4'h5, 1'b1);
    for (int f = 0; f < 3; f++) expect_frame("rr_s0", 4'b0001, 16'h1234, 4'h5, 1'b1);
    for (int f = 0; f < 3; f++) expect_frame("rr_s1", 4'b0010, 16'h5678, 4'hA, 1'b1);
    expect_frame("rr_s0b", 4'b0001, 16'h1234, 4'h5, 1'b1);

    // Granted source leaves during HOLD: the other requester takes over.
    req = 4'b0010;
    expect_frame("swap_last", 4'b0001, 16'h1234, 4'h5, 1'b1);
    for (int c = 0; c < 6; c++) begin
      check("mid.grant", 16'(grant), 16'h2);
      @(negedge clk);
    end
    check("mid.an", 16'(an), 16'hD);
    check("mid.num", 16'(num), 16'h7);
    check("mid.other", 16'(other), 16'h1);

    // Asynchronous reset mid-frame clears everything before the next edge.
    #2 rst = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_frame("rearb_wait", 4'b0000, 16'h5678, 4'hA, 1'b1);
    expect_frame("rearb_g", 4'b0010, 16'h5678, 4'hA, 1'b1);

    // Blink on source 0: phase toggles every 2 frames counted from reset.
    do_reset();
    req   = 4'b0001;
    blink = 4'b0001;
`ifdef DISP_ARBITER_BLINK_EN
    vis_a = 1'b0;
    vis_b = 1'b1;
`else
    vis_a = 1'b1;
    vis_b = 1'b1;
`endif
    expect_frame("blink_wait", 4'b0000, 16'h1234, 4'h5, 1'b1);
    expect_frame("blink_v0", 4'b0001, 16'h1234, 4'h5, vis_b);
    expect_frame("blink_h0", 4'b0001, 16'h1234, 4'h5, vis_a);
    expect_frame("blink_h1", 4'b0001, 16'h1234, 4'h5, vis_a);
    expect_frame("blink_v1", 4'b0001, 16'h1234, 4'h5, vis_b);
    expect_frame("blink_v2", 4'b0001, 16'h1234, 4'h5, vis_b);
    expect_frame("blink_h2", 4'b0001, 16'h1234, 4'h5, vis_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
